symbol_aligner: RTL

- Sits directly upstream of the comma-detection stage in the PHY receive path.
- Takes raw, unaligned 10-bit parallel words from the deserializer and searches all 10 bit offsets for the K28.5 comma.
- Confirms lock over several commas, then delivers symbol-aligned 10-bit words downstream, ahead of comma detection and 8b/10b decode.
- Bit 9 of each word is the first bit received on the line.

---
 rtl/symbol_aligner_if.sv | 31 +++
 rtl/symbol_aligner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/symbol_aligner_if.sv
// Raw-word input and aligned-symbol output bundle for symbol_aligner.
// The master drives deserializer words and the slave (the aligner) returns aligned symbols.
interface symbol_aligner_if;
  logic [9:0] data_in;
  logic       data_in_valid;
  logic [9:0] data_out;
  logic       data_out_valid;
  logic       aligned;
  logic [3:0] align_offset;
  logic       realign_pulse;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_out,
    input  data_out_valid,
    input  aligned,
    input  align_offset,
    input  realign_pulse
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_out,
    output data_out_valid,
    output aligned,
    output align_offset,
    output realign_pulse
  );
endinterface

// File: rtl/symbol_aligner.sv
// K28.5 comma search over all 10 bit offsets with lock confirmation and loss detection.
// Define SYMBOL_ALIGNER_RDPOS_EN to also accept the RD+ form of K28.5 as a comma.
module symbol_aligner #(
  parameter int unsigned CONFIRM_CNT = 2,
  parameter int unsigned LOSS_CNT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  symbol_aligner_if.slave  bus_if
);

  localparam logic [9:0] COMMA_NEG   = 10'b0011111010;
`ifdef SYMBOL_ALIGNER_RDPOS_EN
  localparam logic [9:0] COMMA_POS   = 10'b1100000101;
`endif
  localparam logic [3:0] CONFIRM_LIM = 4'(CONFIRM_CNT);
  localparam logic [3:0] LOSS_LIM    = 4'(LOSS_CNT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t     state_q;
  logic [9:0] prev_word_q;
  logic [9:0] data_out_q;
  logic       data_out_valid_q;
  logic       aligned_q;
  logic       realign_pulse_q;
  logic [3:0] align_offset_q;
  logic [3:0] cnt_q;
  logic [3:0] miss_cnt_q;

  logic [19:0] win;
  logic [9:0]  cand_arr [10];
  logic [9:0]  hit;
  logic        any_hit;
  logic        hit_cur;
  logic [3:0]  first_k;
  logic [3:0]  cnt_inc;
  logic [3:0]  miss_inc;

  // Bit 19 of the window is the oldest bit on the line.
  assign win = {prev_word_q, bus_if.data_in};

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_cand
      assign cand_arr[gi] = win[19-gi -: 10];
`ifdef SYMBOL_ALIGNER_RDPOS_EN
      assign hit[gi] = (cand_arr[gi] == COMMA_NEG) || (cand_arr[gi] == COMMA_POS);
`else
      assign hit[gi] = (cand_arr[gi] == COMMA_NEG);
`endif
    end
  endgenerate

  // Descending scan so the lowest hitting offset is the one left in first_k.
  always_comb begin
    first_k = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (hit[k]) begin
        first_k = 4'(k);
      end
    end
  end

  assign any_hit  = |hit;
  assign hit_cur  = hit[align_offset_q];
  assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign miss_inc = (miss_cnt_q == 4'hF) ? miss_cnt_q : miss_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= SEARCH;
      prev_word_q      <= 10'd0;
      data_out_q       <= 10'd0;
      data_out_valid_q <= 1'b0;
      aligned_q        <= 1'b0;
      realign_pulse_q  <= 1'b0;
      align_offset_q   <= 4'd0;
      cnt_q            <= 4'd0;
      miss_cnt_q       <= 4'd0;
    end else begin
      realign_pulse_q  <= 1'b0;
      data_out_valid_q <= bus_if.data_in_valid;
      if (bus_if.data_in_valid) begin
        data_out_q  <= cand_arr[align_offset_q];
        prev_word_q <= bus_if.data_in;
        case (state_q)
          SEARCH: begin
            if (any_hit) begin
              align_offset_q <= first_k;
              cnt_q          <= 4'd1;
              if (CONFIRM_LIM == 4'd1) begin
                state_q   <= LOCKED;
                aligned_q <= 1'b1;
              end else begin
                state_q <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (hit_cur) begin
              cnt_q <= cnt_inc;
              if (cnt_inc >= CONFIRM_LIM) begin
                state_q   <= LOCKED;
                aligned_q <= 1'b1;
              end
            end else if (any_hit) begin
              align_offset_q <= first_k;
              cnt_q          <= 4'd1;
            end
          end
          LOCKED: begin
            // A comma at the locked offset outranks any foreign comma in the same window.
            if (hit_cur) begin
              miss_cnt_q <= 4'd0;
            end else if (any_hit) begin
              if (miss_inc >= LOSS_LIM) begin
                state_q         <= SEARCH;
                aligned_q       <= 1'b0;
                realign_pulse_q <= 1'b1;
                cnt_q           <= 4'd0;
                miss_cnt_q      <= 4'd0;
              end else begin
                miss_cnt_q <= miss_inc;
              end
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign bus_if.data_out       = data_out_q;
  assign bus_if.data_out_valid = data_out_valid_q;
  assign bus_if.aligned        = aligned_q;
  assign bus_if.align_offset   = align_offset_q;
  assign bus_if.realign_pulse  = realign_pulse_q;

endmodule
